// File: rtl/rd_writeback_pkg.sv
// Shared opcode constants, FSM state and rd-source class encodings for the
// write-back sequencer.
package rd_writeback_pkg;

   localparam logic [6:0] OP_LUI     = 7'b0110111;
   localparam logic [6:0] OP_AUIPC   = 7'b0010111;
   localparam logic [6:0] OP_JAL     = 7'b1101111;
   localparam logic [6:0] OP_JALR    = 7'b1100111;
   localparam logic [6:0] OP_OP      = 7'b0110011;
   localparam logic [6:0] OP_OPIMM   = 7'b0010011;
   localparam logic [6:0] OP_LOAD    = 7'b0000011;
   localparam logic [6:0] OP_STORE   = 7'b0100011;
   localparam logic [6:0] OP_BRANCH  = 7'b1100011;
   localparam logic [6:0] OP_MISCMEM = 7'b0001111;
   localparam logic [6:0] OP_SYSTEM  = 7'b1110011;

   typedef enum logic [1:0] {
      IDLE,
      EXECUTE,
      MEM_WAIT,
      WRITEBACK
   } state_t;

   typedef enum logic [2:0] {
      SRC_NONE,
      SRC_MEM,
      SRC_ALU,
      SRC_IMM,
      SRC_BRANCH,
      SRC_ILLEGAL
   } rd_source_t;

endpackage

// File: rtl/rd_source_decoder.sv
// Combinational RV32I opcode classifier: picks which unit feeds rd, if any.
module rd_source_decoder
   import rd_writeback_pkg::*;
(
   input  logic [6:0] opcode,
   output rd_source_t source
);

   always_comb begin
      source = SRC_ILLEGAL;
      case (opcode)
         OP_LUI, OP_AUIPC:                               source = SRC_IMM;
         OP_JAL, OP_JALR:                                source = SRC_BRANCH;
         OP_OP, OP_OPIMM:                                source = SRC_ALU;
         OP_LOAD:                                        source = SRC_MEM;
         OP_STORE, OP_BRANCH, OP_MISCMEM, OP_SYSTEM:     source = SRC_NONE;
         default:                                        source = SRC_ILLEGAL;
      endcase
   end

endmodule

// File: rtl/rd_writeback_sequencer.sv
// Write-back source sequencer: one instruction at a time, one-hot rd source
// enables, loads held for mem_ready. Optional load timeout: JZJCOREF_RD_MEM_TIMEOUT_EN.
module rd_writeback_sequencer
   import rd_writeback_pkg::*;
#(
   parameter int MEM_TIMEOUT = 15
) (
   input  logic       clock,
   input  logic       reset,
   // Handshake: an instruction transfers on a rising edge where instr_valid && instr_ready;
   // instr_ready is high exactly in IDLE and instr_valid is ignored otherwise.
   input  logic       instr_valid,
   output logic       instr_ready,
   input  logic [6:0] opcode,
   input  logic [4:0] rd_index,
   input  logic       mem_ready,
   output logic       mem_request,
   output logic       memoryOutputEnable,
   output logic       aluOutputEnable,
   output logic       immediateFormerOutputEnable,
   output logic       branchALUOutputEnable,
   output logic       rd_write_enable,
   output logic [4:0] rd_write_index,
   output logic       instr_done,
   output logic       illegal_opcode,
   output logic       mem_timeout,
   output state_t     debugState
);

   if (MEM_TIMEOUT < 1 || MEM_TIMEOUT > 255) begin : gBadTimeout
      $error("MEM_TIMEOUT must be within 1..255");
   end

   state_t     state;
   rd_source_t acceptClass;
   rd_source_t srcClass;
   logic [4:0] rdLatched;
   logic       accept;

   assign accept     = instr_valid && instr_ready;
   assign debugState = state;

   rd_source_decoder uDecoder (
      .opcode (opcode),
      .source (acceptClass)
   );

`ifdef JZJCOREF_RD_MEM_TIMEOUT_EN
   localparam int CountWidth = $clog2(MEM_TIMEOUT + 1);
   localparam logic [CountWidth-1:0] LastWait = CountWidth'(MEM_TIMEOUT - 1);
   logic [CountWidth-1:0] waitCount;
`else
   assign mem_timeout = 1'b0;
`endif

   // Outputs are registered for the state being entered, so each pulse lasts one cycle.
   always_ff @(posedge clock) begin
      instr_ready                 <= 1'b0;
      mem_request                 <= 1'b0;
      memoryOutputEnable          <= 1'b0;
      aluOutputEnable             <= 1'b0;
      immediateFormerOutputEnable <= 1'b0;
      branchALUOutputEnable       <= 1'b0;
      rd_write_enable             <= 1'b0;
      rd_write_index              <= 5'd0;
      instr_done                  <= 1'b0;
      illegal_opcode              <= 1'b0;
`ifdef JZJCOREF_RD_MEM_TIMEOUT_EN
      mem_timeout                 <= 1'b0;
`endif
      if (reset) begin
         state       <= IDLE;
         srcClass    <= SRC_NONE;
         rdLatched   <= 5'd0;
         instr_ready <= 1'b1;
`ifdef JZJCOREF_RD_MEM_TIMEOUT_EN
         waitCount   <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  state     <= EXECUTE;
                  srcClass  <= acceptClass;
                  rdLatched <= rd_index;
                  case (acceptClass)
                     SRC_MEM:     mem_request                 <= 1'b1;
                     SRC_ALU:     aluOutputEnable             <= 1'b1;
                     SRC_IMM:     immediateFormerOutputEnable <= 1'b1;
                     SRC_BRANCH:  branchALUOutputEnable       <= 1'b1;
                     SRC_ILLEGAL: illegal_opcode              <= 1'b1;
                     default:     ;
                  endcase
                  if (acceptClass != SRC_MEM) instr_done <= 1'b1;
                  if ((acceptClass == SRC_ALU || acceptClass == SRC_IMM ||
                       acceptClass == SRC_BRANCH) && rd_index != 5'd0) begin
                     rd_write_enable <= 1'b1;
                     rd_write_index  <= rd_index;
                  end
               end else begin
                  instr_ready <= 1'b1;
               end
            end
            EXECUTE: begin
               if (srcClass == SRC_MEM) begin
                  state <= MEM_WAIT;
`ifdef JZJCOREF_RD_MEM_TIMEOUT_EN
                  waitCount <= '0;
`endif
               end else begin
                  state       <= IDLE;
                  instr_ready <= 1'b1;
               end
            end
            MEM_WAIT: begin
               if (mem_ready) begin
                  state              <= WRITEBACK;
                  memoryOutputEnable <= 1'b1;
                  instr_done         <= 1'b1;
                  if (rdLatched != 5'd0) begin
                     rd_write_enable <= 1'b1;
                     rd_write_index  <= rdLatched;
                  end
               end
`ifdef JZJCOREF_RD_MEM_TIMEOUT_EN
               else if (waitCount == LastWait) begin
                  state       <= IDLE;
                  instr_ready <= 1'b1;
                  mem_timeout <= 1'b1;
                  instr_done  <= 1'b1;
               end else begin
                  waitCount <= waitCount + CountWidth'(1);
               end
`endif
            end
            WRITEBACK: begin
               state       <= IDLE;
               instr_ready <= 1'b1;
            end
            default: begin
               state       <= IDLE;
               instr_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rd_writeback_sequencer.sv
// Directed bench for rd_writeback_sequencer; every non-ready output activity
// is matched against a queue of expected output vectors.
module tb_rd_writeback_sequencer;
   import rd_writeback_pkg::*;

   logic       clock;
   logic       reset;
   logic       instr_valid;
   logic       instr_ready;
   logic [6:0] opcode;
   logic [4:0] rd_index;
   logic       mem_ready;
   logic       mem_request;
   logic       memoryOutputEnable;
   logic       aluOutputEnable;
   logic       immediateFormerOutputEnable;
   logic       branchALUOutputEnable;
   logic       rd_write_enable;
   logic [4:0] rd_write_index;
   logic       instr_done;
   logic       illegal_opcode;
   logic       mem_timeout;
   state_t     debugState;

   int compared = 0;
   int mismatched = 0;
   logic [13:0] exp_q[$];
   logic [13:0] obsVec;

   rd_writeback_sequencer #(.MEM_TIMEOUT(3)) dut (
      .clock                       (clock),
      .reset                       (reset),
      .instr_valid                 (instr_valid),
      .instr_ready                 (instr_ready),
      .opcode                      (opcode),
      .rd_index                    (rd_index),
      .mem_ready                   (mem_ready),
      .mem_request                 (mem_request),
      .memoryOutputEnable          (memoryOutputEnable),
      .aluOutputEnable             (aluOutputEnable),
      .immediateFormerOutputEnable (immediateFormerOutputEnable),
      .branchALUOutputEnable       (branchALUOutputEnable),
      .rd_write_enable             (rd_write_enable),
      .rd_write_index              (rd_write_index),
      .instr_done                  (instr_done),
      .illegal_opcode              (illegal_opcode),
      .mem_timeout                 (mem_timeout),
      .debugState                  (debugState)
   );

   // clock / reset
   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish (observed=timeout expected=finish)");
      $fatal(1);
   end

   assign obsVec = {memoryOutputEnable, aluOutputEnable, immediateFormerOutputEnable,
                    branchALUOutputEnable, rd_write_enable, rd_write_index,
                    instr_done, illegal_opcode, mem_timeout, mem_request};

   function automatic logic [13:0] mk(input logic memE, input logic aluE, input logic immE,
                                      input logic brE, input logic we, input logic [4:0] idx,
                                      input logic done, input logic ill, input logic to,
                                      input logic req);
      return {memE, aluE, immE, brE, we, idx, done, ill, to, req};
   endfunction

   // Expected EXECUTE-cycle outputs for a non-load instruction.
   function automatic logic [13:0] expectFor(input logic [6:0] op, input logic [4:0] rd);
      logic we;
      logic [4:0] idx;
      we  = (rd != 5'd0);
      idx = we ? rd : 5'd0;
      case (op)
         7'b0110111, 7'b0010111: return mk(0, 0, 1, 0, we, idx, 1, 0, 0, 0);
         7'b1101111, 7'b1100111: return mk(0, 0, 0, 1, we, idx, 1, 0, 0, 0);
         7'b0110011, 7'b0010011: return mk(0, 1, 0, 0, we, idx, 1, 0, 0, 0);
         7'b0100011, 7'b1100011, 7'b0001111, 7'b1110011:
                                 return mk(0, 0, 0, 0, 0, 5'd0, 1, 0, 0, 0);
         default:                return mk(0, 0, 0, 0, 0, 5'd0, 1, 1, 0, 0);
      endcase
   endfunction

   function automatic logic [13:0] loadWb(input logic [4:0] rd);
      return mk(1, 0, 0, 0, rd != 5'd0, (rd != 5'd0) ? rd : 5'd0, 1, 0, 0, 0);
   endfunction

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      compared++;
      assert (observed === expected)
      else begin
         mismatched++;
         $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // scoreboard: any output activity must match the head of exp_q
   always @(negedge clock) begin
      if (obsVec != 14'd0) begin
         if (exp_q.size() == 0) check("unexpected_output", 32'(obsVec), 32'd0);
         else check("scoreboard", 32'(obsVec), 32'(exp_q.pop_front()));
      end
   end

   // driver: present one instruction for one accept edge; returns mid cycle N+1
   task automatic issue(input logic [6:0] op, input logic [4:0] rd);
      instr_valid = 1'b1;
      opcode      = op;
      rd_index    = rd;
      @(negedge clock);
      instr_valid = 1'b0;
      opcode      = 7'($urandom_range(0, 127));
      rd_index    = 5'($urandom_range(0, 31));
   endtask

   logic [6:0] tblOp [8];
   logic [4:0] tblRd [8];

   initial begin
      reset       = 1'b1;
      instr_valid = 1'b0;
      opcode      = 7'd0;
      rd_index    = 5'd0;
      mem_ready   = 1'b0;

      repeat (3) @(negedge clock);
      check("reset_outputs", 32'(obsVec), 32'd0);
      check("reset_ready", 32'(instr_ready), 32'd1);
      check("reset_state", 32'(debugState), 32'(IDLE));
      reset = 1'b0;
      repeat (2) @(negedge clock);
      check("idle_outputs", 32'(obsVec), 32'd0);
      check("idle_ready", 32'(instr_ready), 32'd1);

      // OP rd=5, mem_ready high outside MEM_WAIT must be ignored
      mem_ready = 1'b1;
      exp_q.push_back(mk(0, 1, 0, 0, 1, 5'd5, 1, 0, 0, 0));
      issue(7'b0110011, 5'd5);
      check("op_exec_ready", 32'(instr_ready), 32'd0);
      check("op_exec_state", 32'(debugState), 32'(EXECUTE));
      @(negedge clock);
      check("op_ready_back", 32'(instr_ready), 32'd1);
      mem_ready = 1'b0;

      tblOp[0] = 7'b0110111; tblRd[0] = 5'd0;
      tblOp[1] = 7'b1101111; tblRd[1] = 5'd1;
      tblOp[2] = 7'b0010011; tblRd[2] = 5'd31;
      tblOp[3] = 7'b0010111; tblRd[3] = 5'd17;
      tblOp[4] = 7'b1100111; tblRd[4] = 5'd2;
      tblOp[5] = 7'b1111111; tblRd[5] = 5'd7;
      tblOp[6] = 7'b0100011; tblRd[6] = 5'd3;
      tblOp[7] = 7'b1110011; tblRd[7] = 5'd9;
      for (int i = 0; i < 8; i++) begin
         exp_q.push_back(expectFor(tblOp[i], tblRd[i]));
         issue(tblOp[i], tblRd[i]);
         @(negedge clock);
         check("table_ready_back", 32'(instr_ready), 32'd1);
      end

      // LOAD rd=10, mem_ready after 4 MEM_WAIT cycles, instr_valid ignored meanwhile
      exp_q.push_back(mk(0, 0, 0, 0, 0, 5'd0, 0, 0, 0, 1));
      exp_q.push_back(loadWb(5'd10));
      issue(7'b0000011, 5'd10);
      check("load_exec_ready", 32'(instr_ready), 32'd0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clock);
         instr_valid = 1'b1;
         opcode      = 7'b0110011;
         rd_index    = 5'd6;
         check("load_wait_state", 32'(debugState), 32'(MEM_WAIT));
         check("load_wait_ready", 32'(instr_ready), 32'd0);
      end
      @(negedge clock);
      instr_valid = 1'b0;
      mem_ready   = 1'b1;
      @(negedge clock);
      mem_ready = 1'b0;
      check("load_wb_state", 32'(debugState), 32'(WRITEBACK));
      @(negedge clock);
      check("load_ready_back", 32'(instr_ready), 32'd1);

      // reset while waiting on memory drops the load
      exp_q.push_back(mk(0, 0, 0, 0, 0, 5'd0, 0, 0, 0, 1));
      issue(7'b0000011, 5'd9);
      @(negedge clock);
      check("rst_wait_state", 32'(debugState), 32'(MEM_WAIT));
      reset     = 1'b1;
      mem_ready = 1'b1;
      @(negedge clock);
      check("rst_wait_outputs", 32'(obsVec), 32'd0);
      check("rst_wait_idle", 32'(debugState), 32'(IDLE));
      check("rst_wait_ready", 32'(instr_ready), 32'd1);
      reset     = 1'b0;
      mem_ready = 1'b0;
      @(negedge clock);
      check("post_rst_outputs", 32'(obsVec), 32'd0);

`ifdef JZJCOREF_RD_MEM_TIMEOUT_EN
      // MEM_TIMEOUT=3: abandon after the third MEM_WAIT cycle
      exp_q.push_back(mk(0, 0, 0, 0, 0, 5'd0, 0, 0, 0, 1));
      exp_q.push_back(mk(0, 0, 0, 0, 0, 5'd0, 1, 0, 1, 0));
      issue(7'b0000011, 5'd4);
      repeat (3) @(negedge clock);
      @(negedge clock);
      check("timeout_state", 32'(debugState), 32'(IDLE));
      check("timeout_ready", 32'(instr_ready), 32'd1);
      @(negedge clock);

      // mem_ready on the last allowed cycle wins over the timeout
      exp_q.push_back(mk(0, 0, 0, 0, 0, 5'd0, 0, 0, 0, 1));
      exp_q.push_back(loadWb(5'd12));
      issue(7'b0000011, 5'd12);
      repeat (3) @(negedge clock);
      mem_ready = 1'b1;
      @(negedge clock);
      mem_ready = 1'b0;
      check("late_ready_state", 32'(debugState), 32'(WRITEBACK));
      @(negedge clock);
`endif

      repeat (2) @(negedge clock);
      check("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/rd_writeback_sequencer.md
# rd_writeback_sequencer

Multi-cycle control block that drives the rd-source select side of the write-back path. It accepts one decoded instruction at a time, classifies its RV32I opcode, and drives exactly one source-enable line (memory, ALU, immediate former, branch ALU) together with the register-file write strobe and index. Loads are held until the memory subsystem signals data ready. It sits between the instruction decode/control logic and the rd input chooser, and is the only producer of the enable lines that the chooser consumes.

## Interface
- MEM_TIMEOUT, 15: maximum MEM_WAIT cycles before a load is abandoned; only used when the timeout feature is compiled in; legal range 1..255.
- clock  in  1  single core clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high; sampled on the rising edge of clock.
- instr_valid  in  1  a new instruction is presented this cycle.
- instr_ready  out  1  high only in IDLE; an instruction is accepted when instr_valid && instr_ready.
- opcode  in  7  instruction bits [6:0]; sampled on accept only.
- rd_index  in  5  destination register; sampled on accept only.
- mem_ready  in  1  load data valid on memoryOutput; sampled in MEM_WAIT only.
- mem_request  out  1  one-cycle pulse in EXECUTE for LOAD.
- memoryOutputEnable / aluOutputEnable / immediateFormerOutputEnable / branchALUOutputEnable  out  1 each  one-hot source select; at most one high in any cycle.
- rd_write_enable  out  1  register-file write strobe.
- rd_write_index  out  5  latched rd_index; 0 whenever rd_write_enable is low.
- instr_done  out  1  one-cycle completion pulse.
- illegal_opcode  out  1  one-cycle pulse coincident with instr_done for an unknown opcode.
- mem_timeout  out  1  one-cycle pulse when a load is abandoned (timeout build only; tied 0 otherwise).

## Operation
- States: IDLE, EXECUTE, MEM_WAIT, WRITEBACK. Moore outputs, decoded from state plus registers latched on accept.
- Classification of the latched opcode: 0110111 LUI, 0010111 AUIPC -> immediate; 1101111 JAL, 1100111 JALR -> branch ALU; 0110011 OP, 0010011 OP-IMM -> ALU; 0000011 LOAD -> memory; 0100011, 1100011, 0001111, 1110011 -> no write-back; any other value -> illegal, no write-back.
- IDLE -> EXECUTE on accept.
- EXECUTE, non-load: assert the class enable; assert rd_write_enable if the class writes and rd != 0; pulse instr_done; -> IDLE.
- EXECUTE, load: pulse mem_request; no enables; -> MEM_WAIT; clear the wait counter.
- MEM_WAIT: when mem_ready=1, -> WRITEBACK; otherwise stay and increment the counter.
- WRITEBACK: assert memoryOutputEnable; assert rd_write_enable if rd != 0; pulse instr_done; -> IDLE.
- rd = 0: the source enable is still asserted, rd_write_enable stays 0, and instr_done still pulses.
- Reset in any state: the next state is IDLE, all outputs are 0, and the latched opcode, rd and counter are cleared; an in-flight load is dropped silently.

## Timing
- Reset values: instr_ready=1 (IDLE); every other output 0.
- Accept at cycle N.
- Non-load: enables, write and instr_done at N+1; instr_ready high again at N+2.
- Load: mem_request at N+1; MEM_WAIT from N+2. If mem_ready is high at cycle M, write and instr_done occur at M+1, and instr_ready returns at M+2. Minimum load latency is 3 cycles (M = N+2).
- mem_ready is ignored outside MEM_WAIT.
- instr_valid is ignored while instr_ready=0. No queuing.

## Configuration
- JZJCOREF_RD_MEM_TIMEOUT_EN defined:
  - Counter width is $clog2(MEM_TIMEOUT+1).
  - If the MEM_WAIT cycle with counter == MEM_TIMEOUT-1 sees mem_ready=0, the next state is IDLE with mem_timeout=1 and instr_done=1, and there is no write.
  - mem_ready high on that same cycle takes priority: normal WRITEBACK.
- JZJCOREF_RD_MEM_TIMEOUT_EN undefined: no counter; MEM_WAIT waits indefinitely; mem_timeout is constant 0.

## Structure
- Package rd_writeback_pkg contains:
  - the opcode localparams;
  - the state enum state_t;
  - the class enum rd_source_t {SRC_NONE, SRC_MEM, SRC_ALU, SRC_IMM, SRC_BRANCH, SRC_ILLEGAL}.
- Sub-module rd_source_decoder: purely combinational, maps opcode to rd_source_t. It is instantiated once, on the accept path, and the class is latched into a register.

## Test plan
- Reset, then hold: all outputs 0, instr_ready=1. Repeat with reset asserted in MEM_WAIT: IDLE next cycle and no write.
- OP (0110011), rd=5: cycle N+1 has aluOutputEnable=1, rd_write_enable=1, rd_write_index=5, instr_done=1; cycle N+2 has instr_ready=1.
- LUI, rd=0: immediateFormerOutputEnable=1, rd_write_enable=0, instr_done=1.
- LOAD, rd=10, mem_ready raised 4 cycles into MEM_WAIT: exactly one mem_request pulse, then memoryOutputEnable plus write to x10 one cycle after mem_ready; instr_valid pulses during the wait are not accepted.
- Opcode 1111111: illegal_opcode=1 and instr_done=1 at N+1, no enable, no write. STORE: instr_done only.
- Timeout build, MEM_TIMEOUT=3, mem_ready held 0: mem_timeout=1 and instr_done=1 in the cycle after the third MEM_WAIT cycle, no write. A second run with mem_ready on the third MEM_WAIT cycle gets a normal write-back.
